mult_datapath: RTL and testbench

Datapath for the sequential shift-add multiplier. It consumes the one-hot control strobes clr, ld, ldp, shp and shb from the multiplier control FSM. It holds the multiplicand, multiplier and accumulator registers and counts processed bits. Because the FSM loops s2→s3→s4 with no terminal state, this block detects completion, freezes itself, and presents a registered product with a done flag.

---
 rtl/mult_pkg.sv | 44 ++++
 rtl/mult_bit_counter.sv | 51 +++++
 rtl/mult_datapath.sv | 157 +++++++++++++++
 tb/tb_mult_datapath.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-add multiplier.
//   DEFAULT_WIDTH  : default operand width in bits
//   STB_*          : bit positions of the control strobes in the packed
//                    vector {shb, shp, ld, ldp, clr}, shared with the FSM
//   action_e       : the one strobe that acts in a given cycle
//   cnt_width()    : width of the processed-bit counter, clog2(WIDTH+1)
//   decode_strobes(): fixed priority clr > ld > ldp > shp > shb
// ---------------------------------------------------------------------------
package mult_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam int STB_CLR = 0;
   localparam int STB_LDP = 1;
   localparam int STB_LD  = 2;
   localparam int STB_SHP = 3;
   localparam int STB_SHB = 4;
   localparam int NUM_STB = 5;

   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_CLR,
      ACT_LD,
      ACT_LDP,
      ACT_SHP,
      ACT_SHB
   } action_e;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   function automatic action_e decode_strobes(input logic [NUM_STB-1:0] stb);
      if (stb[STB_CLR])      return ACT_CLR;
      else if (stb[STB_LD])  return ACT_LD;
      else if (stb[STB_LDP]) return ACT_LDP;
      else if (stb[STB_SHP]) return ACT_SHP;
      else if (stb[STB_SHB]) return ACT_SHB;
      else                   return ACT_NONE;
   endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// ---------------------------------------------------------------------------
// mult_bit_counter
// Counts processed multiplier bits from 0 up to WIDTH and saturates there.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clr_i       : clear to zero
//   zero_i      : load zero (start of a new multiply)
//   inc_i       : advance by one (ignored once terminal)
//   count_o     : current count
//   last_o      : count == WIDTH-1 (next increment completes the multiply)
//   term_o      : count == WIDTH
// ---------------------------------------------------------------------------
module mult_bit_counter
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CW    = cnt_width(WIDTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_i,
   input  logic          zero_i,
   input  logic          inc_i,
   output logic [CW-1:0] count_o,
   output logic          last_o,
   output logic          term_o
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign count_o = count_q;
   assign last_o  = (count_q == CW'(WIDTH - 1));
   assign term_o  = (count_q == CW'(WIDTH));

   always_comb begin
      count_d = count_q;
      if (clr_i || zero_i)
         count_d = '0;
      else if (inc_i && !term_o)
         count_d = count_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

// File: rtl/mult_datapath.sv
// ---------------------------------------------------------------------------
// mult_datapath
// Shift-add multiplier datapath driven by one-hot strobes from the control
// FSM. The FSM never terminates, so this block detects completion itself,
// freezes (busy=0) and presents a registered product with a sticky done.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   clr           : clear working registers and flags (product holds)
//   ld            : load a_in/b_in and start a multiply
//   ldp           : P += M when Q[0]=1
//   shp           : M <<= 1
//   shb           : Q >>= 1, count one processed bit
//   a_in, b_in    : unsigned operands, sampled on ld
//   product       : registered result, valid while done=1
//   done          : sticky completion flag
//   result_valid  : one-cycle pulse when done rises
//   busy          : multiply in progress
//   bit_cnt       : number of bits processed
// ---------------------------------------------------------------------------
module mult_datapath
   import mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clr,
   input  logic                        ld,
   input  logic                        ldp,
   input  logic                        shp,
   input  logic                        shb,
   input  logic [WIDTH-1:0]            a_in,
   input  logic [WIDTH-1:0]            b_in,
   output logic [2*WIDTH-1:0]          product,
   output logic                        done,
   output logic                        result_valid,
   output logic                        busy,
   output logic [cnt_width(WIDTH)-1:0] bit_cnt
);

   localparam int CW = cnt_width(WIDTH);

   logic [2*WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               rv_q, rv_d;

   logic               cnt_clr, cnt_zero, cnt_inc;
   logic               cnt_last, cnt_term;
   logic [NUM_STB-1:0] stb;
   action_e            act;

   assign stb[STB_CLR] = clr;
   assign stb[STB_LDP] = ldp;
   assign stb[STB_LD]  = ld;
   assign stb[STB_SHP] = shp;
   assign stb[STB_SHB] = shb;
   assign act          = decode_strobes(stb);

   mult_bit_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_bit_counter (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (cnt_clr),
      .zero_i  (cnt_zero),
      .inc_i   (cnt_inc),
      .count_o (bit_cnt),
      .last_o  (cnt_last),
      .term_o  (cnt_term)
   );

   always_comb begin
      m_d       = m_q;
      q_d       = q_q;
      p_d       = p_q;
      product_d = product_q;
      done_d    = done_q;
      busy_d    = busy_q;
      rv_d      = 1'b0;       // result_valid is a single-cycle pulse
      cnt_clr   = 1'b0;
      cnt_zero  = 1'b0;
      cnt_inc   = 1'b0;

      unique case (act)
         ACT_CLR: begin
            m_d     = '0;
            q_d     = '0;
            p_d     = '0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            cnt_clr = 1'b1;
         end
         ACT_LD: begin
            m_d      = {{WIDTH{1'b0}}, a_in};
            q_d      = b_in;
            p_d      = '0;
            done_d   = 1'b0;
            busy_d   = 1'b1;
            cnt_zero = 1'b1;
         end
         ACT_LDP: begin
            if (busy_q && q_q[0])
               p_d = p_q + m_q;
         end
         ACT_SHP: begin
            if (busy_q)
               m_d = m_q << 1;
         end
         ACT_SHB: begin
            // cnt_term guard keeps the counter from ever passing WIDTH
            if (busy_q && !cnt_term) begin
               q_d     = q_q >> 1;
               cnt_inc = 1'b1;
               if (cnt_last) begin
                  // last ldp already happened, so P is final here
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  product_d = p_q;
                  rv_d      = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_q       <= '0;
         q_q       <= '0;
         p_q       <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         rv_q      <= 1'b0;
      end else begin
         m_q       <= m_d;
         q_q       <= q_d;
         p_q       <= p_d;
         product_q <= product_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         rv_q      <= rv_d;
      end
   end

   assign product      = product_q;
   assign done         = done_q;
   assign busy         = busy_q;
   assign result_valid = rv_q;

endmodule

// File: tb/tb_mult_datapath.sv
// ---------------------------------------------------------------------------
// tb_mult_datapath
// Directed-vector bench for mult_datapath (WIDTH=8) with hand-computed
// expected products and flag values.
// ---------------------------------------------------------------------------
module tb_mult_datapath;
   import mult_pkg::*;

   localparam int W  = 8;
   localparam int CW = cnt_width(W);

   logic            clk = 1'b0;
   logic            reset;
   logic            clr, ld, ldp, shp, shb;
   logic [W-1:0]    a_in, b_in;
   logic [2*W-1:0]  product;
   logic            done, result_valid, busy;
   logic [CW-1:0]   bit_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mult_datapath #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .clr          (clr),
      .ld           (ld),
      .ldp          (ldp),
      .shp          (shp),
      .shb          (shb),
      .a_in         (a_in),
      .b_in         (b_in),
      .product      (product),
      .done         (done),
      .result_valid (result_valid),
      .busy         (busy),
      .bit_cnt      (bit_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   // one clock with the given strobes, outputs sampled 1 time unit after the edge
   task automatic cyc(input logic c, input logic l, input logic lp,
                      input logic sp, input logic sb);
      clr = c; ld = l; ldp = lp; shp = sp; shb = sb;
      @(posedge clk);
      #1;
      clr = 0; ld = 0; ldp = 0; shp = 0; shb = 0;
   endtask

   task automatic run_bits(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(0, 0, 1, 0, 0);
         cyc(0, 0, 0, 1, 0);
         cyc(0, 0, 0, 0, 1);
      end
   endtask

   task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
      a_in = a; b_in = b;
      cyc(0, 1, 0, 0, 0);
   endtask

   task automatic check_idle_all(input string tag);
      check({tag, ".product"}, 32'(product), 0);
      check({tag, ".done"},    32'(done), 0);
      check({tag, ".rv"},      32'(result_valid), 0);
      check({tag, ".busy"},    32'(busy), 0);
      check({tag, ".bit_cnt"}, 32'(bit_cnt), 0);
   endtask

   initial begin
      reset = 1; clr = 0; ld = 0; ldp = 0; shp = 0; shb = 0;
      a_in = '0; b_in = '0;
      @(posedge clk); @(posedge clk); #1;
      check_idle_all("reset");
      reset = 0;

      // strobes before any ld do nothing
      cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1); cyc(0, 0, 1, 1, 1);
      check_idle_all("pre_ld");

      // 5 x 3 with cycle-exact latency
      cyc(1, 0, 0, 0, 0);
      load(8'd5, 8'd3);
      check("t1.busy_after_ld", 32'(busy), 1);
      check("t1.cnt_after_ld",  32'(bit_cnt), 0);
      run_bits(7);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0);                 // 23rd edge after ld
      check("t1.done_edge23", 32'(done), 0);
      check("t1.cnt_edge23",  32'(bit_cnt), 7);
      cyc(0, 0, 0, 0, 1);                 // 24th edge after ld
      check("t1.done",    32'(done), 1);
      check("t1.rv",      32'(result_valid), 1);
      check("t1.product", 32'(product), 15);
      check("t1.busy",    32'(busy), 0);
      cyc(0, 0, 1, 0, 0);
      check("t1.rv_next",   32'(result_valid), 0);
      check("t1.done_next", 32'(done), 1);

      // 255 x 255
      cyc(1, 0, 0, 0, 0);
      load(8'd255, 8'd255);
      run_bits(8);
      check("t2.product", 32'(product), 65025);
      check("t2.bit_cnt", 32'(bit_cnt), 8);
      check("t2.busy",    32'(busy), 0);
      check("t2.done",    32'(done), 1);

      // reset mid-operation of 7 x 9
      load(8'd7, 8'd9);
      run_bits(4);
      check("t4.cnt_mid", 32'(bit_cnt), 4);
      reset = 1;
      cyc(0, 0, 1, 0, 0);
      reset = 0;
      check_idle_all("t4.reset");
      load(8'd7, 8'd9);
      run_bits(8);
      check("t4.product", 32'(product), 63);
      check("t4.done",    32'(done), 1);

      // 0xA5 x 0, then the FSM keeps looping
      cyc(1, 0, 0, 0, 0);
      load(8'hA5, 8'd0);
      run_bits(8);
      check("t3.product", 32'(product), 0);
      check("t3.done",    32'(done), 1);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, (i % 3) == 0, (i % 3) == 1, (i % 3) == 2);
         check($sformatf("t3.loop%0d.rv", i), 32'(result_valid), 0);
      end
      check("t3.loop.product", 32'(product), 0);
      check("t3.loop.bit_cnt", 32'(bit_cnt), 8);
      check("t3.loop.done",    32'(done), 1);

      // ld and ldp together: ld wins
      a_in = 8'd12; b_in = 8'd10;
      cyc(0, 1, 1, 0, 0);
      check("t5.p_after_ld",  32'(dut.p_q), 0);
      check("t5.q_after_ld",  32'(dut.q_q), 10);
      check("t5.busy",        32'(busy), 1);
      check("t5.done_clear",  32'(done), 0);
      run_bits(8);
      check("t5.product", 32'(product), 120);
      // clr mid-operation
      load(8'd12, 8'd10);
      run_bits(2);
      cyc(1, 1, 0, 0, 0);                 // clr beats ld
      check("t5.clr.busy",    32'(busy), 0);
      check("t5.clr.done",    32'(done), 0);
      check("t5.clr.bit_cnt", 32'(bit_cnt), 0);
      check("t5.clr.product", 32'(product), 120);

      // idle strobes after clr change nothing
      run_bits(2);
      check("t6.idle.bit_cnt", 32'(bit_cnt), 0);
      check("t6.idle.busy",    32'(busy), 0);
      check("t6.idle.product", 32'(product), 120);

      // 13 x 11, then ld re-issued after done
      load(8'd13, 8'd11);
      run_bits(7);
      cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 1, 0);
      check("t6.rv_before", 32'(result_valid), 0);
      cyc(0, 0, 0, 0, 1);
      check("t6.rv",      32'(result_valid), 1);
      check("t6.product", 32'(product), 143);
      load(8'd13, 8'd11);
      check("t6.reld.done",    32'(done), 0);
      check("t6.reld.busy",    32'(busy), 1);
      check("t6.reld.bit_cnt", 32'(bit_cnt), 0);
      check("t6.reld.product", 32'(product), 143);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
